clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable clock divider for the display and peripheral subsystems (OLED SPI/I2C bit clocks, refresh timers).
- Each channel produces a 50%-duty divided clock and a single-cycle tick strobe from one system clock.
- Half-period is reprogrammed at runtime through a shared config port. New values take effect only at a period boundary, so output edges never glitch.
- Each channel can be started and stopped cleanly, and always stops with its output low.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, width of the half-period value and counter.
- DIV_DEFAULT, 25, reset half-period for all channels in clk cycles. The value 25 gives 1 MHz from 50 MHz.
- CH_W, derived, max(1, clog2(NUM_CH)); width of cfg_ch.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run request (level).
- cfg_wr  in  1  one-cycle write strobe for a half-period value.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_half  in  CNT_W  new half-period, legal range 1..2^CNT_W-1.
- cfg_err  out  1  one-cycle pulse flagging an illegal write.
- cfg_pend  out  NUM_CH  written value is waiting for a period boundary.
- clk_out  out  NUM_CH  divided clock per channel.
- tick  out  NUM_CH  one-cycle pulse when clk_out rises.
- busy  out  NUM_CH  channel is running.

Behaviour:
- Reset state (rst sampled high at an edge):
  - active half-period hp[ch] = DIV_DEFAULT; pending register cleared.
  - cnt = 0; clk_out = 0; tick = 0; busy = 0; cfg_pend = 0; cfg_err = 0.
  - rst overrides all other inputs, including when asserted mid-period or mid-stop.
- Per-channel FSM, states IDLE, RUN, STOPPING:
  - IDLE: cnt held at 0, clk_out = 0. If en = 1 is sampled at edge E0, go to RUN at E0 with busy = 1.
  - RUN: cnt counts 0..hp-1. When cnt == hp-1 at an edge: cnt <= 0 and clk_out toggles.
    - clk_out rises at E0+hp and falls at E0+2hp, so period = 2*hp cycles.
    - hp = 1 gives clk/2.
  - RUN, en sampled 0: if clk_out = 0, go to IDLE immediately (cnt <= 0, busy <= 0). If clk_out = 1, go to STOPPING.
  - STOPPING: keeps counting. At the 1->0 toggle go to IDLE with cnt = 0. If en returns to 1 in STOPPING, go back to RUN and the period continues undisturbed.
- tick: registered; high for exactly the cycle in which clk_out first reads 1 after a 0->1 toggle. It never fires in IDLE or on a falling edge.
- Config write (cfg_wr = 1):
  - If cfg_ch >= NUM_CH or cfg_half == 0: write ignored, cfg_err = 1 in the next cycle, no state change.
  - Otherwise: pending[cfg_ch] <= cfg_half and cfg_pend[cfg_ch] <= 1. A later write before it is applied overwrites it.
- Applying a pending value:
  - In RUN/STOPPING: applied at the edge where clk_out toggles 1->0 (full-period boundary). That same edge loads hp and clears cfg_pend.
  - In IDLE: applied on the next edge.
  - If a write coincides with a boundary edge, the boundary applies the previously pending value (if any). The new write becomes pending and is applied at the following boundary.
- Counter arithmetic: CNT_W-bit unsigned. A compare of cnt == hp-1 is the only terminal condition; cnt never exceeds hp-1. After a shrink the new hp is used only from cnt = 0.
- Channels are fully independent. A write to one channel never disturbs another channel's phase.

Test Plan:
- Default run: NUM_CH=2, release rst, en[0]=1 at E0 -> clk_out[0] rises E0+25, falls E0+50, period 50 cycles; tick[0] high one cycle at E0+25, E0+75, and so on; clk_out[1] stays 0.
- Reprogram mid-period: running hp=25; at E0+10 write cfg_ch=0, cfg_half=4 -> cfg_pend[0]=1 until E0+50; after that clk_out[0] has period 8; no short or long pulse.
- Stop while high: en[0] dropped at E0+30 (clk_out=1) -> clk_out falls at E0+50, busy[0] drops at E0+50, cnt=0; dropped at E0+60 (clk_out=0) -> busy[0]=0 at E0+60.
- Illegal writes: cfg_half=0 or cfg_ch=2 -> cfg_err pulses one cycle, hp and cfg_pend unchanged.
- Edge cases: cfg_half=1 -> clk/2 output; a write coincident with a boundary is applied one period later; simultaneous writes while stopping are applied at the stop edge.
- Reset mid-operation: assert rst at E0+37 in RUN with a pending value -> next cycle all outputs are 0, hp = 25, cfg_pend = 0; re-enable gives a period of 50.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Brief    : Multi-channel runtime-programmable 50%-duty clock divider with
//            glitch-free half-period reload at full-period boundaries.
// Revision : 1.0
// ============================================================================
module clk_div_prog #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 25,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CH_W:0]    c_NUM_CH      = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] c_DIV_DEFAULT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    logic w_cfg_legal;
    logic r_cfg_err;

    assign w_cfg_legal = ({1'b0, cfg_ch} < c_NUM_CH) && (cfg_half != '0);
    assign cfg_err     = r_cfg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_cfg_legal;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_hp;
        logic [CNT_W-1:0] w_hp_nxt;
        logic [CNT_W-1:0] r_pending;
        logic [CNT_W-1:0] w_pending_nxt;
        logic             r_clk;
        logic             w_clk_nxt;
        logic             r_tick;
        logic             w_tick_nxt;
        logic             r_pend;
        logic             w_pend_nxt;
        logic             w_apply;
        logic             w_term;
        logic             w_wr_hit;

        assign w_term   = (r_cnt == r_hp - c_ONE);
        assign w_wr_hit = cfg_wr && w_cfg_legal && (cfg_ch == CH_W'(gi));

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_clk_nxt     = r_clk;
            w_tick_nxt    = 1'b0;
            w_apply       = 1'b0;
            w_pending_nxt = r_pending;
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    w_clk_nxt = 1'b0;
                    w_apply   = r_pend;
                    if (en[gi]) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (!en[gi] && !r_clk) begin
                        // Output already low: stop without finishing the period
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        if (w_term) begin
                            w_cnt_nxt  = '0;
                            w_clk_nxt  = !r_clk;
                            w_tick_nxt = !r_clk;
                            w_apply    = r_clk && r_pend;
                        end else begin
                            w_cnt_nxt = r_cnt + c_ONE;
                        end
                        if (en[gi]) begin
                            w_state_nxt = ST_RUN;
                        end else if (w_term) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_STOPPING;
                        end
                    end
                end
            endcase
            w_hp_nxt   = w_apply ? r_pending : r_hp;
            w_pend_nxt = w_apply ? 1'b0 : r_pend;
            // A write landing on the apply edge becomes the next pending value
            if (w_wr_hit) begin
                w_pending_nxt = cfg_half;
                w_pend_nxt    = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_hp      <= c_DIV_DEFAULT;
                r_pending <= '0;
                r_clk     <= 1'b0;
                r_tick    <= 1'b0;
                r_pend    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_hp      <= w_hp_nxt;
                r_pending <= w_pending_nxt;
                r_clk     <= w_clk_nxt;
                r_tick    <= w_tick_nxt;
                r_pend    <= w_pend_nxt;
            end
        end

        assign clk_out[gi]  = r_clk;
        assign tick[gi]     = r_tick;
        assign busy[gi]     = (r_state != ST_IDLE);
        assign cfg_pend[gi] = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_prog
// Brief    : Directed plus randomized bench for clk_div_prog against a
//            time-based behavioural model of each channel.
// Revision : 1.0
// ============================================================================
module tb_clk_div_prog;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 16;
    localparam int DIV_DEFAULT = 25;
    localparam int CH_W        = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // Model: a running channel's output is a pure function of the edges
    // elapsed since the start of its current full period.
    bit m_run     [NUM_CH];
    int m_seg     [NUM_CH];
    int m_hp      [NUM_CH];
    bit m_pend    [NUM_CH];
    int m_pending [NUM_CH];
    bit m_tick    [NUM_CH];
    bit m_err;

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DIV_DEFAULT(DIV_DEFAULT),
        .CH_W       (CH_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_half(cfg_half),
        .cfg_err (cfg_err),
        .cfg_pend(cfg_pend),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    function automatic bit model_hi(input int ch);
        return m_run[ch] && ((t - m_seg[ch]) >= m_hp[ch]);
    endfunction

    function automatic bit next_boundary(input int ch);
        return m_run[ch] && ((t + 1 - m_seg[ch]) == 2 * m_hp[ch]);
    endfunction

    task automatic model_edge(input bit r, input logic [NUM_CH-1:0] e,
                              input bit w, input int c, input int h);
        t++;
        if (r) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_run[ch]     = 1'b0;
                m_seg[ch]     = t;
                m_hp[ch]      = DIV_DEFAULT;
                m_pend[ch]    = 1'b0;
                m_pending[ch] = 0;
                m_tick[ch]    = 1'b0;
            end
            m_err = 1'b0;
            return;
        end
        m_err = w && ((c >= NUM_CH) || (h == 0));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_tick[ch] = 1'b0;
            if (m_run[ch]) begin
                int el;
                bit was_hi;
                el     = t - m_seg[ch];
                was_hi = (el - 1) >= m_hp[ch];
                if (!e[ch] && !was_hi) begin
                    m_run[ch] = 1'b0;
                end else begin
                    if (el == m_hp[ch]) m_tick[ch] = 1'b1;
                    if (el == 2 * m_hp[ch]) begin
                        m_seg[ch] = t;
                        if (m_pend[ch]) begin
                            m_hp[ch]   = m_pending[ch];
                            m_pend[ch] = 1'b0;
                        end
                        if (!e[ch]) m_run[ch] = 1'b0;
                    end
                end
            end else begin
                if (m_pend[ch]) begin
                    m_hp[ch]   = m_pending[ch];
                    m_pend[ch] = 1'b0;
                end
                if (e[ch]) begin
                    m_run[ch] = 1'b1;
                    m_seg[ch] = t;
                end
            end
            if (w && (c == ch) && (h != 0)) begin
                m_pending[ch] = h;
                m_pend[ch]    = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] x_clk, x_tick, x_busy, x_pend;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            x_clk[ch]  = model_hi(ch);
            x_tick[ch] = m_tick[ch];
            x_busy[ch] = m_run[ch];
            x_pend[ch] = m_pend[ch];
        end
        n_tests++;
        assert (clk_out === x_clk) else begin
            n_fail++;
            $error("FAIL clk_out t=%0d got %b exp %b", t, clk_out, x_clk);
        end
        n_tests++;
        assert (tick === x_tick) else begin
            n_fail++;
            $error("FAIL tick t=%0d got %b exp %b", t, tick, x_tick);
        end
        n_tests++;
        assert (busy === x_busy) else begin
            n_fail++;
            $error("FAIL busy t=%0d got %b exp %b", t, busy, x_busy);
        end
        n_tests++;
        assert (cfg_pend === x_pend) else begin
            n_fail++;
            $error("FAIL cfg_pend t=%0d got %b exp %b", t, cfg_pend, x_pend);
        end
        n_tests++;
        assert (cfg_err === m_err) else begin
            n_fail++;
            $error("FAIL cfg_err t=%0d got %b exp %b", t, cfg_err, m_err);
        end
    endtask

    task automatic step(input bit r, input logic [NUM_CH-1:0] e,
                        input bit w, input int c, input int h);
        rst      = r;
        en       = e;
        cfg_wr   = w;
        cfg_ch   = c[CH_W-1:0];
        cfg_half = h[CNT_W-1:0];
        @(posedge clk);
        model_edge(r, e, w, c, h);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [NUM_CH-1:0] e_cur;
        rst = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0;

        // Reset state
        repeat (3) step(1, 3'b000, 0, 0, 0);

        // Default run on channel 0
        step(0, 3'b001, 0, 0, 0);
        repeat (130) step(0, 3'b001, 0, 0, 0);

        // Stop while high: wait for a high phase, drop en part-way in
        for (int k = 0; k < 100 && model_hi(0); k++) step(0, 3'b001, 0, 0, 0);
        for (int k = 0; k < 100 && !model_hi(0); k++) step(0, 3'b001, 0, 0, 0);
        repeat (5) step(0, 3'b001, 0, 0, 0);
        repeat (40) step(0, 3'b000, 0, 0, 0);

        // Reprogram 10 cycles into a period
        step(0, 3'b001, 0, 0, 0);
        repeat (9) step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 1, 0, 4);
        repeat (60) step(0, 3'b001, 0, 0, 0);

        // Stop while low
        for (int k = 0; k < 20 && model_hi(0); k++) step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        repeat (5) step(0, 3'b000, 0, 0, 0);

        // Illegal writes: zero half-period and out-of-range channel
        step(0, 3'b000, 1, 0, 0);
        step(0, 3'b000, 1, 3, 7);
        step(0, 3'b000, 0, 0, 0);

        // Half-period of 1 on channel 1 (clk/2)
        step(0, 3'b000, 1, 1, 1);
        repeat (12) step(0, 3'b010, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);

        // Write coincident with a period boundary on channel 0 (hp = 4)
        repeat (3) step(0, 3'b001, 0, 0, 0);
        for (int k = 0; k < 20 && !next_boundary(0); k++) step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 1, 0, 3);
        repeat (20) step(0, 3'b001, 0, 0, 0);

        // Write issued while stopping is applied at the stop edge
        for (int k = 0; k < 20 && !model_hi(0); k++) step(0, 3'b001, 0, 0, 0);
        step(0, 3'b000, 1, 0, 6);
        repeat (6) step(0, 3'b000, 0, 0, 0);
        repeat (30) step(0, 3'b001, 0, 0, 0);

        // Reset in the middle of a period with a pending value
        step(0, 3'b000, 1, 0, 25);
        repeat (3) step(0, 3'b000, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        repeat (36) step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 1, 0, 9);
        step(1, 3'b001, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        repeat (110) step(0, 3'b001, 0, 0, 0);

        // Randomized traffic on all channels
        e_cur = 3'b011;
        for (int k = 0; k < 3000; k++) begin
            bit w;
            int c, h;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 99) < 3) e_cur[ch] = ~e_cur[ch];
            end
            w = ($urandom_range(0, 99) < 6);
            c = $urandom_range(0, 3);
            h = $urandom_range(0, 12);
            step(($urandom_range(0, 999) < 3), e_cur, w, c, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
